z16_fetch_stage: RTL and testbench

//  Instruction fetch stage of the Z16 CPU. Holds the program counter and drives the

---
 rtl/z16_fetch_stage.sv | 91 +++++++++
 tb/tb_z16_fetch_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/z16_fetch_stage.sv
// Z16 instruction fetch stage: program counter, combinational instruction memory address,
// and an IF/ID register handed to decode through a valid/ready handshake.
module z16_fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [15:0] o_imem_addr,
    input  logic [15:0] i_imem_instr,
    output logic [15:0] o_instr,
    output logic [15:0] o_pc,
    output logic        o_valid,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_halted
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic        fire;

    // Instructions are 16-bit aligned, so the low address bit is always dropped.
    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

    function automatic logic [15:0] next_pc(input logic [15:0] addr);
        return addr + PC_STEP;
    endfunction

    assign o_imem_addr = pc;

    // The IF/ID slot may be refilled when it is empty or is being drained this cycle.
    assign fire = (state == S_RUN) && !i_redirect && (!o_valid || i_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_BOOT;
            pc       <= RESET_PC;
            o_instr  <= 16'h0000;
            o_pc     <= 16'h0000;
            o_valid  <= 1'b0;
            o_halted <= 1'b0;
        end else if (i_redirect) begin
            // Redirect overrides halt and drops whatever sits in IF/ID.
            state    <= S_RUN;
            pc       <= align_pc(i_redirect_pc);
            o_valid  <= 1'b0;
            o_halted <= 1'b0;
        end else begin
            if (fire) begin
                o_instr <= i_imem_instr;
                o_pc    <= pc;
                o_valid <= 1'b1;
                pc      <= next_pc(pc);
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                S_BOOT: begin
                    state    <= S_RUN;
                    o_halted <= 1'b0;
                end
                S_RUN: begin
                    if (i_halt) begin
                        state    <= S_HALT;
                        o_halted <= 1'b1;
                    end
                end
                S_HALT: begin
                    o_halted <= 1'b1;
                end
                default: begin
                    state    <= S_BOOT;
                    o_halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z16_fetch_stage.sv
// Randomized scoreboard bench for z16_fetch_stage: a transaction-level model predicts
// every instruction handed to decode, and a monitor compares each handshake against it.
module tb_z16_fetch_stage;

    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } fetch_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic [15:0] instr;
    logic [15:0] pc_out;
    logic        valid;
    logic        ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;

    logic [15:0] mem [0:32767];

    int errors = 0;
    int checks = 0;

    // Model state: predicted PC, boot/halt status, and the expected IF/ID contents.
    fetch_t      exp_q[$];
    logic [15:0] m_pc   = RESET_PC;
    logic        m_boot = 1'b1;
    logic        m_halt = 1'b0;

    z16_fetch_stage #(.RESET_PC(RESET_PC), .PC_STEP(16'd2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_imem_addr  (imem_addr),
        .i_imem_instr (imem_instr),
        .o_instr      (instr),
        .o_pc         (pc_out),
        .o_valid      (valid),
        .i_ready      (ready),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .i_halt       (halt),
        .o_halted     (halted)
    );

    assign imem_instr = mem[imem_addr[15:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_pc   = RESET_PC;
            m_boot = 1'b1;
            m_halt = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            if (redirect) m_pc = {redirect_pc[15:1], 1'b0};
        end else if (redirect) begin
            exp_q.delete();
            m_pc   = {redirect_pc[15:1], 1'b0};
            m_halt = 1'b0;
        end else begin
            if (!m_halt && (exp_q.size() == 0 || ready)) begin
                exp_q.push_back('{pc: m_pc, instr: mem[m_pc[15:1]]});
                m_pc = m_pc + 16'd2;
            end
            if (halt) m_halt = 1'b1;
        end
    end

    always @(negedge clk) begin
        fetch_t e;
        check("valid", {15'b0, valid}, {15'b0, exp_q.size() != 0});
        check("imem_addr", imem_addr, m_pc);
        check("halted", {15'b0, halted}, {15'b0, m_halt});
        if (!rst_n) begin
            check("reset_pc", pc_out, 16'h0000);
            check("reset_instr", instr, 16'h0000);
        end
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL handshake: got pc %h instr %h expected no instruction", pc_out, instr);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", pc_out, e.pc);
                check("out_instr", instr, e.instr);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        rst_n       = 1'b0;
        ready       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        step(2);
        rst_n = 1'b1;

        // boot cycle, then words at 0 and 2; stall while 0x0002 is held
        step(3);
        ready = 1'b0;
        step(3);
        ready = 1'b1;
        step(2);

        // redirect to an odd target while stalled
        ready = 1'b0;
        step(1);
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        step(1);
        redirect = 1'b0;
        ready    = 1'b1;
        step(3);

        // halt pulse, then resume by redirect
        halt = 1'b1;
        step(1);
        halt = 1'b0;
        step(3);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        step(1);
        redirect = 1'b0;
        step(3);

        // redirect plus halt in one cycle: halt must be ignored
        redirect    = 1'b1;
        halt        = 1'b1;
        redirect_pc = 16'h0200;
        step(1);
        redirect = 1'b0;
        halt     = 1'b0;
        step(2);

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step(1);
        redirect = 1'b0;
        step(4);

        for (int i = 0; i < 3000; i++) begin
            ready       = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 16'($urandom);
            halt        = ($urandom_range(0, 29) == 0);
            step(1);
        end
        ready    = 1'b1;
        redirect = 1'b0;
        halt     = 1'b0;
        step(5);

        // asynchronous reset between clock edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_valid", {15'b0, valid}, 16'h0000);
        check("async_addr", imem_addr, RESET_PC);
        step(2);
        rst_n = 1'b1;
        step(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
